tpu_host_seq: RTL and testbench

Host-side sequencer that drives the Mini-TPU pin interface (`ui_in`, `uio_in`, `uo_out`) from the controller end. It takes one 2x2 job at a time, consisting of four weight bytes and four activation bytes. It then emits the pin-level command stream: load weights, load activations, run, wait, read results. It captures the four result bytes from `uo_out` and presents them on a valid/ready result port. It sits between a host or bring-up controller and `tt_um_tpu`, replacing hand-driven stimulus.

---
 rtl/tpu_host_seq.sv | 171 +++++++++++++++++
 tb/tb_tpu_host_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_host_seq.sv
// Host-side sequencer for the Mini-TPU pin interface: loads one 2x2 job, runs it,
// reads back the four result bytes and offers them on a valid/ready port.
module tpu_host_seq #(
   parameter int RUN_CYCLES = 6,
   parameter int READ_LAT   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic [31:0] job_w,
   input  logic [31:0] job_a,
   input  logic        abort,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        busy,
   output logic [7:0]  ui_in,
   output logic [7:0]  uio_in,
   input  logic [7:0]  uo_out
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_W, S_LOAD_A, S_RUN, S_WAIT, S_READ, S_DRAIN, S_DONE
   } state_t;

   localparam logic [2:0] CMD_NOP    = 3'd0;
   localparam logic [2:0] CMD_LOAD_W = 3'd1;
   localparam logic [2:0] CMD_LOAD_A = 3'd2;
   localparam logic [2:0] CMD_RUN    = 3'd3;
   localparam logic [2:0] CMD_READ   = 3'd4;

   localparam logic [7:0] WAIT_LAST  = 8'((RUN_CYCLES == 0) ? 0 : RUN_CYCLES - 1);
   localparam logic [1:0] DRAIN_LAST = 2'((READ_LAT == 0) ? 0 : READ_LAT - 1);

   state_t      state, state_n;
   logic [1:0]  idx, idx_n;
   logic [7:0]  wait_cnt, wait_n;
   logic [1:0]  drain_cnt, drain_n;
   logic [31:0] w_q, a_q, w_src;
   logic [2:0]  cmd_n;
   logic [7:0]  ui_n;
   logic        accept, kill;
   logic        cap_v;
   logic [1:0]  cap_i;

   assign accept    = job_valid && (state == S_IDLE);
   assign kill      = abort && (state != S_IDLE);
   assign job_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign res_valid = (state == S_DONE);

   always_comb begin
      state_n = state;
      idx_n   = idx;
      wait_n  = wait_cnt;
      drain_n = drain_cnt;
      case (state)
         S_IDLE: if (job_valid) begin
            state_n = S_LOAD_W;
            idx_n   = 2'd0;
         end
         S_LOAD_W: begin
            idx_n = idx + 2'd1;
            if (idx == 2'd3) state_n = S_LOAD_A;
         end
         S_LOAD_A: begin
            idx_n = idx + 2'd1;
            if (idx == 2'd3) state_n = S_RUN;
         end
         S_RUN: begin
            idx_n   = 2'd0;
            wait_n  = 8'd0;
            state_n = (RUN_CYCLES == 0) ? S_READ : S_WAIT;
         end
         S_WAIT: begin
            wait_n = wait_cnt + 8'd1;
            if (wait_cnt == WAIT_LAST) state_n = S_READ;
         end
         S_READ: begin
            idx_n   = idx + 2'd1;
            drain_n = 2'd0;
            if (idx == 2'd3) state_n = (READ_LAT == 0) ? S_DONE : S_DRAIN;
         end
         S_DRAIN: begin
            drain_n = drain_cnt + 2'd1;
            if (drain_cnt == DRAIN_LAST) state_n = S_DONE;
         end
         S_DONE: if (res_ready) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (kill) begin
         state_n = S_IDLE;
         idx_n   = 2'd0;
      end
   end

   // Pins are registered from the next state so they line up with the state cycle.
   // The first weight byte is driven straight from job_w on the accept edge.
   always_comb begin
      w_src = accept ? job_w : w_q;
      cmd_n = CMD_NOP;
      ui_n  = 8'd0;
      case (state_n)
         S_LOAD_W: begin cmd_n = CMD_LOAD_W; ui_n = w_src[{idx_n, 3'b000} +: 8]; end
         S_LOAD_A: begin cmd_n = CMD_LOAD_A; ui_n = a_q[{idx_n, 3'b000} +: 8]; end
         S_RUN:    cmd_n = CMD_RUN;
         S_READ:   cmd_n = CMD_READ;
         default:  cmd_n = CMD_NOP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         idx       <= 2'd0;
         wait_cnt  <= 8'd0;
         drain_cnt <= 2'd0;
         w_q       <= 32'd0;
         a_q       <= 32'd0;
         ui_in     <= 8'd0;
         uio_in    <= 8'd0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         wait_cnt  <= wait_n;
         drain_cnt <= drain_n;
         if (accept) begin
            w_q <= job_w;
            a_q <= job_a;
         end
         ui_in  <= ui_n;
         uio_in <= {3'b000, (cmd_n == CMD_NOP || cmd_n == CMD_RUN) ? 2'd0 : idx_n, cmd_n};
      end
   end

   // Capture pipe: {valid, index} of each READ, delayed to match the TPU read latency.
   generate
      if (READ_LAT == 0) begin : g_cap_direct
         assign cap_v = (state == S_READ) && !kill;
         assign cap_i = idx;
      end else begin : g_cap_pipe
         logic [READ_LAT-1:0]      pipe_v;
         logic [READ_LAT-1:0][1:0] pipe_i;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pipe_v <= '0;
               pipe_i <= '0;
            end else if (kill) begin
               pipe_v <= '0;
               pipe_i <= '0;
            end else begin
               pipe_v[0] <= (state == S_READ);
               pipe_i[0] <= idx;
               for (int s = 1; s < READ_LAT; s++) begin
                  pipe_v[s] <= pipe_v[s-1];
                  pipe_i[s] <= pipe_i[s-1];
               end
            end
         end
         assign cap_v = pipe_v[READ_LAT-1] && !kill;
         assign cap_i = pipe_i[READ_LAT-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     res_data <= 32'd0;
      else if (cap_v) res_data[{cap_i, 3'b000} +: 8] <= uo_out;
   end

endmodule

// File: tb/tb_tpu_host_seq.sv
// Directed bench: default-parameter sequencer plus a zero-latency variant,
// each with a small TPU read model on uo_out.
module tb_tpu_host_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // default-parameter instance
   logic        job_valid_d = 1'b0, abort_d = 1'b0, res_ready_d = 1'b0;
   logic [31:0] job_w_d = '0, job_a_d = '0;
   logic        job_ready_d, res_valid_d, busy_d;
   logic [31:0] res_data_d;
   logic [7:0]  ui_d, uio_d;
   logic [7:0]  uo_d = 8'd0;

   // RUN_CYCLES=0, READ_LAT=0 instance
   logic        job_valid_z = 1'b0, abort_z = 1'b0, res_ready_z = 1'b0;
   logic [31:0] job_w_z = '0, job_a_z = '0;
   logic        job_ready_z, res_valid_z, busy_z;
   logic [31:0] res_data_z;
   logic [7:0]  ui_z, uio_z;
   logic [7:0]  uo_z;

   tpu_host_seq dut_d (
      .clk(clk), .rst_n(rst_n), .job_valid(job_valid_d), .job_ready(job_ready_d),
      .job_w(job_w_d), .job_a(job_a_d), .abort(abort_d), .res_valid(res_valid_d),
      .res_ready(res_ready_d), .res_data(res_data_d), .busy(busy_d),
      .ui_in(ui_d), .uio_in(uio_d), .uo_out(uo_d)
   );

   tpu_host_seq #(.RUN_CYCLES(0), .READ_LAT(0)) dut_z (
      .clk(clk), .rst_n(rst_n), .job_valid(job_valid_z), .job_ready(job_ready_z),
      .job_w(job_w_z), .job_a(job_a_z), .abort(abort_z), .res_valid(res_valid_z),
      .res_ready(res_ready_z), .res_data(res_data_z), .busy(busy_z),
      .ui_in(ui_z), .uio_in(uio_z), .uo_out(uo_z)
   );

   // TPU models: registered (1-cycle lag) and combinational
   always @(posedge clk)
      if (uio_d[2:0] == 3'd4) uo_d <= 8'hA0 + {6'd0, uio_d[4:3]};
   assign uo_z = (uio_z[2:0] == 3'd4) ? (8'hC0 + {6'd0, uio_z[4:3]}) : 8'h00;

   // Stimulus only: offers a job to the default instance; returns #1 after the accept edge E_0.
   task automatic start_job_d(input logic [31:0] w, input logic [31:0] a);
      job_w_d = w; job_a_d = a; job_valid_d = 1'b1;
      @(posedge clk); #1;
      job_valid_d = 1'b0; job_w_d = '0; job_a_d = '0;
   endtask

   task automatic test_reset;
      total++; if (ui_d !== 8'd0) begin bad++; $display("FAIL reset_ui got=%h exp=00", ui_d); end
      total++; if (uio_d !== 8'd0) begin bad++; $display("FAIL reset_uio got=%h exp=00", uio_d); end
      total++; if (res_valid_d !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", res_valid_d); end
      total++; if (res_data_d !== 32'd0) begin bad++; $display("FAIL reset_res_data got=%h exp=0", res_data_d); end
      total++; if (job_ready_d !== 1'b1) begin bad++; $display("FAIL reset_job_ready got=%b exp=1", job_ready_d); end
      total++; if (busy_d !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_d); end
      total++; if (uio_z !== 8'd0 || res_valid_z !== 1'b0 || job_ready_z !== 1'b1) begin
         bad++; $display("FAIL reset_zlat got uio=%h rv=%b jr=%b exp 00/0/1", uio_z, res_valid_z, job_ready_z); end
   endtask

   task automatic test_default_job;
      logic [2:0] ec; logic [1:0] ei; logic [7:0] eu;
      start_job_d(32'h04030201, 32'h08070605);
      for (int k = 0; k <= 20; k++) begin
         ec = 3'd0; ei = 2'd0; eu = 8'd0;
         if (k < 4)                 begin ec = 3'd1; ei = 2'(k);      eu = 8'(k + 1); end
         else if (k < 8)            begin ec = 3'd2; ei = 2'(k - 4);  eu = 8'(k + 1); end
         else if (k == 8)           ec = 3'd3;
         else if (k >= 15 && k < 19) begin ec = 3'd4; ei = 2'(k - 15); end
         total++; if (uio_d !== {3'b000, ei, ec}) begin
            bad++; $display("FAIL def_uio c%0d got=%h exp=%h", k, uio_d, {3'b000, ei, ec}); end
         total++; if (ui_d !== eu) begin
            bad++; $display("FAIL def_ui c%0d got=%h exp=%h", k, ui_d, eu); end
         total++; if (res_valid_d !== (k >= 20)) begin
            bad++; $display("FAIL def_res_valid c%0d got=%b exp=%b", k, res_valid_d, (k >= 20)); end
         if (k < 20) begin @(posedge clk); #1; end
      end
      total++; if (res_data_d !== 32'hA3A2A1A0) begin
         bad++; $display("FAIL def_res_data got=%h exp=a3a2a1a0", res_data_d); end
   endtask

   // Entered in DONE with res_ready low.
   task automatic test_done_hold;
      job_w_d = 32'h55555555; job_a_d = 32'h66666666; job_valid_d = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         total++; if (res_valid_d !== 1'b1 || res_data_d !== 32'hA3A2A1A0) begin
            bad++; $display("FAIL hold_result c%0d got rv=%b data=%h exp 1/a3a2a1a0", k, res_valid_d, res_data_d); end
         total++; if (uio_d !== 8'd0 || ui_d !== 8'd0) begin
            bad++; $display("FAIL hold_pins c%0d got uio=%h ui=%h exp 00/00", k, uio_d, ui_d); end
         total++; if (job_ready_d !== 1'b0) begin
            bad++; $display("FAIL hold_job_ready c%0d got=%b exp=0", k, job_ready_d); end
      end
      job_valid_d = 1'b0; res_ready_d = 1'b1;
      @(posedge clk); #1;
      res_ready_d = 1'b0;
      total++; if (job_ready_d !== 1'b1 || res_valid_d !== 1'b0 || busy_d !== 1'b0) begin
         bad++; $display("FAIL hold_release got jr=%b rv=%b busy=%b exp 1/0/0", job_ready_d, res_valid_d, busy_d); end
      total++; if (res_data_d !== 32'hA3A2A1A0) begin
         bad++; $display("FAIL hold_data_kept got=%h exp=a3a2a1a0", res_data_d); end
   endtask

   task automatic test_zero_lat;
      logic [2:0] ec; logic [1:0] ei; logic [7:0] eu;
      job_w_z = 32'h14131211; job_a_z = 32'h18171615; job_valid_z = 1'b1;
      @(posedge clk); #1;
      job_valid_z = 1'b0; job_w_z = '0; job_a_z = '0;
      for (int k = 0; k <= 13; k++) begin
         ec = 3'd0; ei = 2'd0; eu = 8'd0;
         if (k < 4)       begin ec = 3'd1; ei = 2'(k);     eu = 8'(8'h11 + k); end
         else if (k < 8)  begin ec = 3'd2; ei = 2'(k - 4); eu = 8'(8'h11 + k); end
         else if (k == 8) ec = 3'd3;
         else if (k < 13) begin ec = 3'd4; ei = 2'(k - 9); end
         total++; if (uio_z !== {3'b000, ei, ec} || ui_z !== eu) begin
            bad++; $display("FAIL zlat_pins c%0d got uio=%h ui=%h exp %h/%h", k, uio_z, ui_z, {3'b000, ei, ec}, eu); end
         total++; if (res_valid_z !== (k >= 13)) begin
            bad++; $display("FAIL zlat_res_valid c%0d got=%b exp=%b", k, res_valid_z, (k >= 13)); end
         if (k < 13) begin @(posedge clk); #1; end
      end
      total++; if (res_data_z !== 32'hC3C2C1C0) begin
         bad++; $display("FAIL zlat_res_data got=%h exp=c3c2c1c0", res_data_z); end
      res_ready_z = 1'b1;
      @(posedge clk); #1;
      res_ready_z = 1'b0;
      total++; if (job_ready_z !== 1'b1) begin bad++; $display("FAIL zlat_release got=%b exp=1", job_ready_z); end
   endtask

   task automatic test_back_to_back;
      int rise1, rise2, acc2;
      rise1 = -1; rise2 = -1; acc2 = -1;
      res_ready_d = 1'b1;
      job_w_d = 32'h04030201; job_a_d = 32'h08070605; job_valid_d = 1'b1;
      @(posedge clk); #1;   // E_0
      job_w_d = 32'h0D0C0B0A;
      for (int k = 0; k <= 50; k++) begin
         if (res_valid_d && rise1 < 0) rise1 = k;
         else if (res_valid_d && rise1 >= 0 && k == rise1 + 1) begin
            bad++; total++; $display("FAIL b2b_valid_width got=2+ cycles exp=1");
         end
         if (acc2 < 0 && uio_d == 8'h01 && k > 0) begin
            acc2 = k;
            total++; if (ui_d !== 8'h0A) begin bad++; $display("FAIL b2b_second_byte got=%h exp=0a", ui_d); end
            job_valid_d = 1'b0;
         end
         if (acc2 >= 0 && res_valid_d && rise2 < 0 && k > acc2) rise2 = k;
         @(posedge clk); #1;
      end
      res_ready_d = 1'b0;
      total++; if (rise1 !== 20) begin bad++; $display("FAIL b2b_first_rise got=%0d exp=20", rise1); end
      // second accept is at E_22, so its LOAD_W idx0 shows in cycle 22
      total++; if (acc2 !== 22) begin bad++; $display("FAIL b2b_second_accept got=%0d exp=22", acc2); end
      total++; if (rise2 !== 42) begin bad++; $display("FAIL b2b_second_rise got=%0d exp=42", rise2); end
      total++; if (job_ready_d !== 1'b1) begin bad++; $display("FAIL b2b_final_idle got=%b exp=1", job_ready_d); end
   endtask

   task automatic test_abort;
      int seen;
      seen = 0;
      start_job_d(32'h44332211, 32'h88776655);
      repeat (10) @(posedge clk);
      #1;                                  // cycle 10, in WAIT
      total++; if (busy_d !== 1'b1 || uio_d !== 8'd0) begin
         bad++; $display("FAIL abort_pre got busy=%b uio=%h exp 1/00", busy_d, uio_d); end
      abort_d = 1'b1;
      @(posedge clk); #1;                  // cycle 11
      abort_d = 1'b0;
      total++; if (uio_d !== 8'd0 || ui_d !== 8'd0) begin
         bad++; $display("FAIL abort_pins got uio=%h ui=%h exp 00/00", uio_d, ui_d); end
      total++; if (job_ready_d !== 1'b1 || busy_d !== 1'b0) begin
         bad++; $display("FAIL abort_idle got jr=%b busy=%b exp 1/0", job_ready_d, busy_d); end
      for (int k = 0; k < 25; k++) begin
         if (res_valid_d || uio_d != 8'd0) seen++;
         @(posedge clk); #1;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL abort_quiet got=%0d active cycles exp=0", seen); end
      start_job_d(32'h04030201, 32'h08070605);
      repeat (20) @(posedge clk);
      #1;
      total++; if (res_valid_d !== 1'b1 || res_data_d !== 32'hA3A2A1A0) begin
         bad++; $display("FAIL abort_next_job got rv=%b data=%h exp 1/a3a2a1a0", res_valid_d, res_data_d); end
      res_ready_d = 1'b1;
      @(posedge clk); #1;
      res_ready_d = 1'b0;
   endtask

   task automatic test_reset_mid;
      start_job_d(32'h04030201, 32'h08070605);
      repeat (16) @(posedge clk);
      #1;                                  // cycle 16, READ idx 1
      total++; if (uio_d !== 8'h0C) begin bad++; $display("FAIL rst_mid_pre got=%h exp=0c", uio_d); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (ui_d !== 8'd0 || uio_d !== 8'd0 || res_valid_d !== 1'b0) begin
         bad++; $display("FAIL rst_mid_outputs got ui=%h uio=%h rv=%b exp 00/00/0", ui_d, uio_d, res_valid_d); end
      total++; if (res_data_d !== 32'd0 || job_ready_d !== 1'b1) begin
         bad++; $display("FAIL rst_mid_state got data=%h jr=%b exp 0/1", res_data_d, job_ready_d); end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      start_job_d(32'h04030201, 32'h08070605);
      repeat (20) @(posedge clk);
      #1;
      total++; if (res_valid_d !== 1'b1 || res_data_d !== 32'hA3A2A1A0) begin
         bad++; $display("FAIL rst_mid_next_job got rv=%b data=%h exp 1/a3a2a1a0", res_valid_d, res_data_d); end
   endtask

   initial begin
      #12 rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset;
      test_default_job;
      test_done_hold;
      @(posedge clk); #1;
      test_zero_lat;
      @(posedge clk); #1;
      test_back_to_back;
      test_abort;
      @(posedge clk); #1;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
